// File: rtl/ask_mod_if.sv
// Byte handshake between a data source and the ASK transmitter.
// The source drives byte_in/byte_valid; the transmitter answers with byte_ready.
interface ask_mod_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/ask_mod.sv
// On-off ASK transmitter: serialises bytes MSB-first and gates a DDS triangle
// carrier onto a 10-bit offset-binary DAC word, in the 30 MHz sample domain.
module ask_mod #(
  parameter int unsigned P6  = 5000,
  parameter int unsigned P8  = 3750,
  parameter int unsigned P10 = 3000,
  parameter logic [9:0]  MID = 10'd512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [3:0]  rate_sel_i,
  input  logic [31:0] ftw_i,
  ask_mod_if.slave    byte_if,
  output logic [9:0]  dac_out_o,
  output logic        tx_bit_o,
  output logic        bit_start_o,
  output logic        busy_o
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q;
  logic [31:0] phase_q, phase_d;
  logic [7:0]  hold_q, shreg_q;
  logic        hold_full_q, hold_full_d;
  logic        ready_q;
  logic [15:0] per_q, per_d, bit_cnt_q;
  logic [2:0]  bit_idx_q;
  logic        bit_start_q;
  logic [9:0]  dac_q, tri_d;
  logic        accept, bit_last, load;

  always_comb begin
    per_d = 16'(P6);
    case (rate_sel_i)
      4'd8:    per_d = 16'(P8);
      4'd10:   per_d = 16'(P10);
      default: per_d = 16'(P6);
    endcase
  end

  assign phase_d  = phase_q + ftw_i;
  assign tri_d    = phase_q[31] ? ~phase_q[30:21] : phase_q[30:21];
  assign accept   = byte_if.byte_valid & byte_if.byte_ready;
  assign bit_last = (state_q == SEND) && (bit_cnt_q == per_q - 16'd1);

  // A load happens either from IDLE or gaplessly at the end of the eighth bit;
  // ready is registered, so an accept can never coincide with a load.
  assign load        = hold_full_q && ((state_q == IDLE) || (bit_last && (bit_idx_q == 3'd7)));
  assign hold_full_d = accept | (hold_full_q & ~load);

  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      shreg_q     <= '0;
      per_q       <= 16'(P6);
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      bit_start_q <= 1'b0;
      dac_q       <= MID;
    end else begin
      phase_q     <= phase_d;
      dac_q       <= ((state_q == SEND) && shreg_q[7]) ? tri_d : MID;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      bit_start_q <= 1'b0;
      if (accept) begin
        hold_q <= byte_if.byte_in;
      end
      if (load) begin
        state_q     <= SEND;
        shreg_q     <= hold_q;
        per_q       <= per_d;
        bit_cnt_q   <= '0;
        bit_idx_q   <= '0;
        bit_start_q <= 1'b1;
      end else if (state_q == SEND) begin
        if (bit_last) begin
          bit_cnt_q <= '0;
          if (bit_idx_q == 3'd7) begin
            state_q <= IDLE;
          end else begin
            shreg_q     <= {shreg_q[6:0], 1'b0};
            bit_idx_q   <= bit_idx_q + 3'd1;
            bit_start_q <= 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 16'd1;
        end
      end
    end
  end

  assign byte_if.byte_ready = en_i & ready_q;
  assign busy_o             = (state_q == SEND);
  assign tx_bit_o           = (state_q == SEND) & shreg_q[7];
  assign bit_start_o        = bit_start_q;
  assign dac_out_o          = dac_q;

endmodule

// File: tb/tb_ask_mod.sv
// Self-checking bench for ask_mod: a timeline-level model predicts every output
// each cycle, and directed scenarios pin bit timing, gapless queuing and abort.
module tb_ask_mod;

  localparam int TP6  = 60;
  localparam int TP8  = 45;
  localparam int TP10 = 36;
  localparam logic [9:0] MIDV = 10'd512;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  rate_sel;
  logic [31:0] ftw;
  logic [9:0]  dac_out;
  logic        tx_bit, bit_start, busy;

  ask_mod_if bus();

  ask_mod #(.P6(TP6), .P8(TP8), .P10(TP10), .MID(MIDV)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .rate_sel_i  (rate_sel),
    .ftw_i       (ftw),
    .byte_if     (bus),
    .dac_out_o   (dac_out),
    .tx_bit_o    (tx_bit),
    .bit_start_o (bit_start),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Model: a byte in flight is just (byte, rate, cycles elapsed); the bit on
  // air and the bit_start pulse follow by division and remainder.
  bit          mBusy = 1'b0, mHoldFull = 1'b0, mReady = 1'b0, mStart = 1'b0;
  logic [7:0]  mByte = '0, mHold = '0;
  int          mElapsed = 0, mPer = TP6;
  logic [31:0] mPhase = '0;
  logic [9:0]  mDac = MIDV;

  int          cycleNo = 0;
  int          busyCycles = 0;
  int          startTimes[$];
  logic [7:0]  bitsSeen = '0;
  int          dacMin = 1023, dacMax = 0;

  function automatic int perOf(input logic [3:0] r);
    if (r == 4'd8) return TP8;
    if (r == 4'd10) return TP10;
    return TP6;
  endfunction

  function automatic logic [9:0] triOf(input logic [31:0] p);
    int t;
    t = int'(p >> 21);
    if (t < 1024) return 10'(t);
    return 10'(2047 - t);
  endfunction

  function automatic bit txOf();
    int idx;
    if (!mBusy) return 1'b0;
    idx = 7 - mElapsed / mPer;
    return mByte[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    logic [9:0] nextDac;
    bit accept, startNew;
    if (rst || !en) begin
      mBusy = 0; mHoldFull = 0; mReady = 0; mStart = 0;
      mElapsed = 0; mPer = TP6; mPhase = '0; mDac = MIDV;
    end else begin
      nextDac  = (mBusy && txOf()) ? triOf(mPhase) : MIDV;
      accept   = bus.byte_valid && mReady;
      startNew = 0;
      mStart   = 0;
      if (mBusy) begin
        if (mElapsed == 8 * mPer - 1) begin
          if (mHoldFull) startNew = 1;
          else begin mBusy = 0; mElapsed = 0; end
        end else begin
          mElapsed++;
          mStart = (mElapsed % mPer) == 0;
        end
      end else if (mHoldFull) begin
        startNew = 1;
      end
      if (startNew) begin
        mBusy = 1; mByte = mHold; mHoldFull = 0;
        mPer = perOf(rate_sel); mElapsed = 0; mStart = 1;
      end
      if (accept) begin
        mHold = bus.byte_in; mHoldFull = 1;
      end
      mReady = !mHoldFull;
      mPhase = mPhase + ftw;
      mDac   = nextDac;
    end
  endtask

  // Advance the model on each edge, then compare every output just after it.
  always @(posedge clk) begin
    logic [13:0] expV, actV;
    modelStep();
    #1;
    expV = {mBusy, txOf(), mStart, en & mReady, mDac};
    actV = {busy, tx_bit, bit_start, bus.byte_ready, dac_out};
    checkOutput("cycle {busy,tx,start,ready,dac}", 32'(actV), 32'(expV));
    cycleNo++;
    if (busy) begin
      busyCycles++;
      if (int'(dac_out) < dacMin) dacMin = int'(dac_out);
      if (int'(dac_out) > dacMax) dacMax = int'(dac_out);
    end
    if (bit_start) begin
      startTimes.push_back(cycleNo);
      bitsSeen = {bitsSeen[6:0], tx_bit};
    end
  end

  task automatic clearMeasure();
    busyCycles = 0;
    startTimes.delete();
    dacMin = 1023;
    dacMax = 0;
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got timeout, expected completion", name);
  endtask

  // Offer one byte and hold valid until the DUT takes it.
  task automatic applyStimulus(input logic [7:0] b, input logic [3:0] r);
    int n;
    rate_sel = r;
    n = 0;
    while (!bus.byte_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      timeoutFail("ready wait");
      return;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((mBusy || mHoldFull) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeoutFail("idle wait");
  endtask

  task automatic waitStarts(input int count, input int budget);
    int n;
    n = 0;
    while (startTimes.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeoutFail("bit_start wait");
  endtask

  initial begin
    int gap;
    rst = 1'b1;
    en = 1'b1;
    rate_sel = 4'd10;
    ftw = 32'h0100_0000;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset dac_out", 32'(dac_out), 32'd512);
    checkOutput("reset byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", 32'(bus.byte_ready), 32'd1);

    checkOutput("model tri 0x00000000", 32'(triOf(32'h0000_0000)), 32'd0);
    checkOutput("model tri 0x40000000", 32'(triOf(32'h4000_0000)), 32'd512);
    checkOutput("model tri 0x80000000", 32'(triOf(32'h8000_0000)), 32'd1023);
    checkOutput("model tri 0xC0000000", 32'(triOf(32'hC000_0000)), 32'd511);

    // Single byte 0xA5 at 10 kbps.
    clearMeasure();
    applyStimulus(8'hA5, 4'd10);
    waitIdle(2000);
    checkOutput("A5 busy cycles", 32'(busyCycles), 32'(8 * TP10));
    checkOutput("A5 bit_start count", 32'(startTimes.size()), 32'd8);
    checkOutput("A5 tx_bit sequence", 32'(bitsSeen), 32'h0000_00A5);
    if (startTimes.size() >= 2)
      checkOutput("A5 bit spacing", 32'(startTimes[1] - startTimes[0]), 32'(TP10));

    // Back-to-back 0xFF, 0x00 at 8 kbps.
    clearMeasure();
    applyStimulus(8'hFF, 4'd8);
    applyStimulus(8'h00, 4'd8);
    checkOutput("ready after second accept", 32'(bus.byte_ready), 32'd0);
    waitIdle(4000);
    checkOutput("FF00 busy cycles", 32'(busyCycles), 32'(16 * TP8));
    checkOutput("FF00 bit_start count", 32'(startTimes.size()), 32'd16);
    if (startTimes.size() >= 16)
      checkOutput("FF00 gapless span", 32'(startTimes[15] - startTimes[0]), 32'(15 * TP8));

    // Rate change mid-byte takes effect only at the byte boundary.
    clearMeasure();
    applyStimulus(8'h0F, 4'd6);
    waitStarts(4, 2000);
    rate_sel = 4'd10;
    applyStimulus(8'hF0, 4'd10);
    waitIdle(4000);
    checkOutput("rate change busy", 32'(busyCycles), 32'(8 * TP6 + 8 * TP10));
    if (startTimes.size() >= 16) begin
      checkOutput("byte1 last bit length", 32'(startTimes[8] - startTimes[7]), 32'(TP6));
      checkOutput("byte1 span", 32'(startTimes[8] - startTimes[0]), 32'(8 * TP6));
      checkOutput("byte2 span", 32'(startTimes[15] - startTimes[8]), 32'(7 * TP10));
    end else begin
      timeoutFail("rate change start count");
    end

    // Carrier at 2 MHz with continuous ones; unsupported rate falls back to 6 kbps.
    ftw = 32'h1111_1111;
    clearMeasure();
    applyStimulus(8'hFF, 4'd7);
    waitIdle(2000);
    if (startTimes.size() >= 2)
      checkOutput("rate 7 bit spacing", 32'(startTimes[1] - startTimes[0]), 32'(TP6));
    checkOutput("carrier span >= 850", 32'(dacMax - dacMin >= 850), 32'd1);

    // Abort during bit 4 with a byte held, then restart clean.
    ftw = 32'h0234_5678;
    clearMeasure();
    applyStimulus(8'hC3, 4'd6);
    applyStimulus(8'h55, 4'd6);
    waitStarts(5, 2000);
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort dac_out", 32'(dac_out), 32'd512);
    checkOutput("abort tx_bit", 32'(tx_bit), 32'd0);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    checkOutput("hold cleared, ready", 32'(bus.byte_ready), 32'd1);
    checkOutput("idle after re-enable", 32'(busy), 32'd0);
    clearMeasure();
    applyStimulus(8'h80, 4'd10);
    checkOutput("restart not yet started", 32'(bit_start), 32'd0);
    @(negedge clk);
    checkOutput("restart bit_start", 32'(bit_start), 32'd1);
    checkOutput("restart first bit", 32'(tx_bit), 32'd1);
    waitIdle(2000);
    checkOutput("restart bit count", 32'(startTimes.size()), 32'd8);

    // Randomized traffic: rates, carrier, gaps and enable drops.
    for (int i = 0; i < 30; i++) begin
      logic [3:0] r;
      case ($urandom_range(0, 3))
        0: r = 4'd6;
        1: r = 4'd8;
        2: r = 4'd10;
        default: r = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 3) == 0) ftw = $urandom;
      applyStimulus(8'($urandom_range(0, 255)), r);
      gap = $urandom_range(0, 400);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
      end
    end
    waitIdle(4000);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
